// File: rtl/pkt_accum_params_if.sv
// Stream handshake bundle for pkt_accum_params: input beats with valid/ready,
// and a result channel with valid/ready plus the decoded packet fields.
interface pkt_accum_params_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16,
    parameter int CNT_W  = 3
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic [RES_W-1:0]  o_result;
    logic [3:0]        o_header;
    logic [1:0]        o_type;
    logic [CNT_W-1:0]  o_count;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_result, o_header, o_type, o_count
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_result, o_header, o_type, o_count
    );
endinterface

// File: rtl/pkt_accum_params.sv
// Packet accumulator: header beat + 1..4 payload beats in, P_INT + payload sum out.
// Define PKT_ACCUM_SATURATE_EN to clamp an overflowing sum instead of wrapping.
module pkt_accum_params #(
    parameter int P_INT  = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int RES_W  = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    pkt_accum_params_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    // Headroom for P_INT plus four full-scale beats before any wrap or clamp.
    localparam int SUM_W = RES_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] header;
        logic [1:0] pkt_type;
    } hdr_t;

    state_t             state_q, state_d;
    hdr_t               hdr_q, hdr_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]  buf_q [DEPTH];
    logic [DATA_W-1:0]  buf_d [DEPTH];
    logic [SUM_W-1:0]   sum_w;
    logic               ready_d, valid_d;
    logic [RES_W-1:0]   result_d;
    logic [3:0]         header_d;
    logic [1:0]         type_d;
    logic [CNT_W-1:0]   count_d;
    logic               accept;

    assign accept = bus.i_valid && bus.o_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        hdr_d    = hdr_q;
        idx_d    = idx_q;
        len_d    = len_q;
        buf_d    = buf_q;
        sum_w    = '0;
        ready_d  = bus.o_ready;
        valid_d  = bus.o_valid;
        result_d = bus.o_result;
        header_d = bus.o_header;
        type_d   = bus.o_type;
        count_d  = bus.o_count;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    hdr_d   = hdr_t'(bus.i_data[DATA_W-1 -: 6]);
                    len_d   = CNT_W'(bus.i_data[DATA_W-5 -: 2]) + CNT_W'(1);
                    idx_d   = '0;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                ready_d = 1'b1;
                if (accept) begin
                    buf_d[idx_q[IDX_W-1:0]] = bus.i_data;
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == len_q - CNT_W'(1)) begin
                        // Sum uses the buffer including the beat landing this cycle.
                        sum_w = SUM_W'(P_INT);
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i < int'(len_q)) sum_w = sum_w + SUM_W'(buf_d[i]);
                        end
`ifdef PKT_ACCUM_SATURATE_EN
                        result_d = (|sum_w[SUM_W-1:RES_W]) ? {RES_W{1'b1}} : sum_w[RES_W-1:0];
`else
                        result_d = sum_w[RES_W-1:0];
`endif
                        header_d = hdr_q.header;
                        type_d   = hdr_q.pkt_type;
                        count_d  = len_q;
                        ready_d  = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            hdr_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            // NOTE: the payload buffer is cleared on reset so no stale beats survive a dropped packet.
            buf_q        <= '{default: '0};
            bus.o_ready  <= 1'b0;
            bus.o_valid  <= 1'b0;
            bus.o_result <= '0;
            bus.o_header <= '0;
            bus.o_type   <= '0;
            bus.o_count  <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            bus.o_ready  <= ready_d;
            bus.o_valid  <= valid_d;
            bus.o_result <= result_d;
            bus.o_header <= header_d;
            bus.o_type   <= type_d;
            bus.o_count  <= count_d;
        end
    end
endmodule

// File: doc/pkt_accum_params.md
# pkt_accum_params

Parametrised packet accumulator: accepts a header beat followed by 1..4 payload beats over a valid/ready stream. Each packet is stored in an internal unpacked buffer and the header/type fields are decoded into a packed struct. The block emits the payload sum plus a constant offset through a second valid/ready handshake. It sits between a byte-stream source and a downstream consumer, generalising the single-cycle data-type/parameter block with width, depth, packet framing and backpressure.

## Interface
- P_INT, 10: constant offset added to every result.
- DATA_W, 8: beat width; must be >= 6.
- DEPTH, 4: payload buffer entries; must be >= 4.
- RES_W, 16: result width; must be >= DATA_W.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset. Synchronous and active-high.
- i_valid  in  1  input beat valid.
- i_data  in  DATA_W  input beat.
- o_ready  out  1  block can accept a beat.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  RES_W  P_INT plus the sum of the payload beats.
- o_header  out  4  header field of the emitted packet.
- o_type  out  2  type field of the emitted packet.
- o_count  out  $clog2(DEPTH)+1  number of payload beats in the emitted packet.

## Operation
- Beat transfer: a beat is accepted when i_valid && o_ready.
- State machine (enum): S_IDLE, S_PAYLOAD, S_DONE.
- S_IDLE
  - o_ready=1.
  - On an accepted beat, decode the header beat: header = i_data[DATA_W-1 -: 4], type = i_data[DATA_W-5 -: 2].
  - Payload length = type+1 beats (1..4). Go to S_PAYLOAD with the beat index at 0.
- S_PAYLOAD
  - o_ready=1.
  - Each accepted beat is written to buf[index] and the index increments.
  - On the beat where index == length-1, go to S_DONE.
  - Cycles with i_valid=0 stall; there is no timeout.
- S_DONE
  - o_ready=0; input beats are ignored.
  - o_valid=1. o_result, o_header, o_type and o_count are held stable.
  - When i_ready=1, go to S_IDLE.
- Arithmetic
  - Each buffer entry is zero-extended to RES_W.
  - o_result = P_INT + sum of the payload beats, computed in RES_W bits.
  - Overflow wraps modulo 2^RES_W (see Configuration for the alternative).
- Reset: all outputs are 0 (o_ready=0 while in reset); state = S_IDLE; buffer and index are cleared.
- Reset mid-packet: the partial packet is discarded. Reset in S_DONE drops the pending result.
- Simultaneous events: i_rst overrides every handshake.

## Timing
- o_ready, o_valid and all result outputs are registered.
- o_ready=1 in the first cycle after i_rst deasserts.
- o_valid rises in the cycle after the last payload beat is accepted.
- Minimum packet latency from header acceptance to o_valid = length+1 cycles.
- After o_valid && i_ready, the next cycle is S_IDLE (o_ready=1, o_valid=0). A new header can be accepted in that cycle.
- Throughput: one packet per length+2 cycles under no backpressure.
- Outputs do not change while o_valid=1 && i_ready=0.

## Configuration
- Macro: PKT_ACCUM_SATURATE_EN.
- Defined: an overflowing sum clamps o_result to 2^RES_W-1.
- Undefined: the sum wraps modulo 2^RES_W.
- All other behaviour is identical in both builds.

## Test plan
- Header 0x84 then payloads 0x10, 0x20, i_ready=1 (defaults) -> o_valid for 1 cycle; o_result=0x003A, o_header=8, o_type=1, o_count=2.
- Header 0x0C then four beats of 0xFF (defaults) -> o_result=0x0406, o_count=4.
- Same packet as the previous scenario with RES_W=8:
  - Macro undefined -> o_result=0x06.
  - PKT_ACCUM_SATURATE_EN defined -> o_result=0xFF.
- Backpressure: i_ready=0 for 3 cycles in S_DONE while i_valid=1 with data 0x55 -> o_valid and o_result held; o_ready=0; 0x55 is not accepted. After i_ready=1, the next header is accepted on the following cycle.
- Reset mid-packet: after header 0x0C and 2 payload beats, pulse i_rst for 1 cycle -> outputs 0, state S_IDLE. A fresh header 0x00 with payload 0x01 -> o_result=0x000B.
- Gapped input: header 0x84 followed by i_valid low for 2 cycles, then 0x01 and 0x02 -> o_result=0x000D. o_valid rises exactly one cycle after the 0x02 beat.
